// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM-stage data-memory access controller. Each aligned load or store becomes
// exactly one request/acknowledge transaction on the data bus. The pipeline
// is stalled until that transaction completes. The unit also handles byte and
// halfword lane steering, sign/zero extension of loads, misaligned-address
// exceptions, and a bus watchdog.
//
// Ports
//   clk, reset        : clock and synchronous active-high reset
//   mem_read[2:0]     : load op (1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, else none)
//   mem_write[1:0]    : store op (1 sw, 2 sh, 3 sb, 0 none)
//   alu_out[31:0]     : effective byte address
//   store_data[31:0]  : store source register value
//   pipe_hold         : another stall source is freezing the pipeline
//   dbus_req/we/addr/wstrb/wdata : registered bus request fields
//   dbus_rdata, dbus_ack         : bus response
//   mem_stall         : combinational pipeline freeze
//   load_data, load_valid        : extended load result for the MEM instruction
//   addr_exc, exc_code, bad_vaddr: misaligned-access exception (combinational)
//   bus_err           : one-cycle pulse when the watchdog expires
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mem_read,
  input  logic [1:0]  mem_write,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  input  logic        pipe_hold,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_exc,
  output logic [4:0]  exc_code,
  output logic [31:0] bad_vaddr,
  output logic        bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(TIMEOUT + 2);

  logic [1:0]    r_state, w_state_next;
  logic          r_req, r_we, r_bus_err;
  logic [31:0]   r_addr, r_wdata, r_load_data;
  logic [3:0]    r_wstrb;
  logic [2:0]    r_ld_op;      // 0 when the active transaction is a store
  logic [1:0]    r_byte_off;   // dbus_addr drops these, extension needs them
  logic [CW-1:0] r_wait_cnt;

  logic          w_is_load, w_is_store, w_misalign, w_go, w_timeout;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata, w_ext;
  logic [7:0]    w_rd_byte [4];
  logic [15:0]   w_rd_half;
  logic [7:0]    w_sel_byte;

  // ---------------- request decode ----------------
  always_comb begin
    w_is_load  = (mem_read >= 3'd1) && (mem_read <= 3'd5);
    // A valid load wins when both fields carry an op.
    w_is_store = !w_is_load && (mem_write != 2'b00);
    w_misalign = 1'b0;
    if (w_is_load) begin
      case (mem_read)
        3'd1:       w_misalign = |alu_out[1:0];
        3'd2, 3'd3: w_misalign = alu_out[0];
        default:    w_misalign = 1'b0;
      endcase
    end else if (w_is_store) begin
      case (mem_write)
        2'b01:   w_misalign = |alu_out[1:0];
        2'b10:   w_misalign = alu_out[0];
        default: w_misalign = 1'b0;
      endcase
    end
  end

  assign w_go      = (w_is_load || w_is_store) && !w_misalign;
  assign addr_exc  = w_misalign;
  assign exc_code  = w_misalign ? (w_is_load ? 5'd4 : 5'd5) : 5'd0;
  assign bad_vaddr = w_misalign ? alu_out : 32'd0;

  // ---------------- store lane steering ----------------
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'd0;
    if (w_is_store) begin
      case (mem_write)
        2'b01: begin
          w_wstrb = 4'b1111;
          w_wdata = store_data;
        end
        2'b10: begin
          w_wstrb = alu_out[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{store_data[15:0]}};
        end
        2'b11: begin
          w_wstrb = 4'b0001 << alu_out[1:0];
          w_wdata = {4{store_data[7:0]}};
        end
        default: begin
          w_wstrb = 4'b0000;
          w_wdata = 32'd0;
        end
      endcase
    end
  end

  // ---------------- load extraction / extension ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
    assign w_rd_byte[gi] = dbus_rdata[8*gi +: 8];
  end

  assign w_sel_byte = w_rd_byte[r_byte_off];
  assign w_rd_half  = r_byte_off[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

  always_comb begin
    case (r_ld_op)
      3'd1:    w_ext = dbus_rdata;
      3'd2:    w_ext = {{16{w_rd_half[15]}}, w_rd_half};
      3'd3:    w_ext = {16'd0, w_rd_half};
      3'd4:    w_ext = {{24{w_sel_byte[7]}}, w_sel_byte};
      3'd5:    w_ext = {24'd0, w_sel_byte};
      default: w_ext = 32'd0;
    endcase
  end

  // The counter starts at 0 on BUSY entry. Leaving on TIMEOUT-1 therefore
  // lands the DONE entry exactly TIMEOUT cycles after BUSY entry.
  assign w_timeout = (TIMEOUT != 0) && (r_wait_cnt == CW'(TIMEOUT - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_state_next = S_BUSY;
      S_BUSY:  if (dbus_ack || w_timeout) w_state_next = S_DONE;
      S_DONE:  if (!pipe_hold) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    mem_stall  = ((r_state == S_IDLE) && w_go) || (r_state == S_BUSY);
    load_valid = (r_state == S_DONE) && (r_ld_op != 3'd0);
  end

  // ---------------- request / response registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wstrb     <= 4'b0000;
      r_wdata     <= 32'd0;
      r_load_data <= 32'd0;
      r_bus_err   <= 1'b0;
      r_ld_op     <= 3'd0;
      r_byte_off  <= 2'b00;
      r_wait_cnt  <= '0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_req      <= 1'b1;
            r_we       <= w_is_store;
            r_addr     <= {alu_out[31:2], 2'b00};
            r_wstrb    <= w_wstrb;
            r_wdata    <= w_wdata;
            r_ld_op    <= w_is_load ? mem_read : 3'd0;
            r_byte_off <= alu_out[1:0];
            r_wait_cnt <= '0;
          end
        end
        S_BUSY: begin
          if (dbus_ack) begin
            r_req <= 1'b0;
            if (r_ld_op != 3'd0) r_load_data <= w_ext;
          end else if (w_timeout) begin
            r_req       <= 1'b0;
            r_load_data <= 32'd0;
            r_bus_err   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dbus_req   = r_req;
  assign dbus_we    = r_we;
  assign dbus_addr  = r_addr;
  assign dbus_wstrb = r_wstrb;
  assign dbus_wdata = r_wdata;
  assign load_data  = r_load_data;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic [31:0] alu_out, store_data;
  logic        pipe_hold;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_ack;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        load_valid, addr_exc;
  logic [4:0]  exc_code;
  logic [31:0] bad_vaddr;
  logic        bus_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .alu_out(alu_out), .store_data(store_data), .pipe_hold(pipe_hold),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
    .addr_exc(addr_exc), .exc_code(exc_code), .bad_vaddr(bad_vaddr),
    .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // All driving and sampling happens at the falling edge (+1 for settling).
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_op(input logic [2:0] rd, input logic [1:0] wr,
                        input logic [31:0] a, input logic [31:0] sd);
    mem_read   = rd;
    mem_write  = wr;
    alu_out    = a;
    store_data = sd;
  endtask

  // Load with same-cycle ack: IDLE, BUSY, DONE, then back to IDLE.
  task automatic run_load(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] rd,
                          input logic [31:0] exp);
    cyc(); set_op(op, 2'b00, a, 32'd0); #1;
    check({name, ".idle_stall"}, mem_stall, 1);
    check({name, ".idle_badv"}, bad_vaddr, 0);
    cyc(); dbus_ack = 1'b1; dbus_rdata = rd; #1;
    check({name, ".req"}, dbus_req, 1);
    check({name, ".we"}, dbus_we, 0);
    check({name, ".wstrb"}, dbus_wstrb, 0);
    check({name, ".addr"}, dbus_addr, {a[31:2], 2'b00});
    cyc(); dbus_ack = 1'b0; dbus_rdata = 32'd0; #1;
    check({name, ".valid"}, load_valid, 1);
    check({name, ".data"}, load_data, exp);
    check({name, ".done_stall"}, mem_stall, 0);
    cyc(); set_op(3'd0, 2'b00, 32'd0, 32'd0); #1;
    check({name, ".valid_off"}, load_valid, 0);
  endtask

  // Store with same-cycle ack.
  task automatic run_store(input string name, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [3:0] strb, input logic [31:0] wd);
    cyc(); set_op(3'd0, op, a, sd); #1;
    check({name, ".idle_stall"}, mem_stall, 1);
    cyc(); dbus_ack = 1'b1; #1;
    check({name, ".req"}, dbus_req, 1);
    check({name, ".we"}, dbus_we, 1);
    check({name, ".wstrb"}, {28'd0, dbus_wstrb}, {28'd0, strb});
    check({name, ".wdata"}, dbus_wdata, wd);
    cyc(); dbus_ack = 1'b0; #1;
    check({name, ".done_req"}, dbus_req, 0);
    check({name, ".no_valid"}, load_valid, 0);
    cyc(); set_op(3'd0, 2'b00, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; pipe_hold = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'd0;
    set_op(3'd0, 2'b00, 32'd0, 32'd0);
    cyc(); cyc(); cyc();
    reset = 1'b0; #1;
    check("rst.req", dbus_req, 0);
    check("rst.we", dbus_we, 0);
    check("rst.addr", dbus_addr, 0);
    check("rst.wstrb", dbus_wstrb, 0);
    check("rst.wdata", dbus_wdata, 0);
    check("rst.load_data", load_data, 0);
    check("rst.valid", load_valid, 0);
    check("rst.bus_err", bus_err, 0);
    check("rst.stall", mem_stall, 0);

    // sw at 0x100, ack after two wait cycles.
    cyc(); set_op(3'd0, 2'b01, 32'h100, 32'hDEADBEEF); #1;
    check("sw.c0_stall", mem_stall, 1);
    check("sw.c0_req", dbus_req, 0);
    cyc(); #1;
    check("sw.c1_req", dbus_req, 1);
    check("sw.c1_stall", mem_stall, 1);
    check("sw.addr", dbus_addr, 32'h100);
    check("sw.wstrb", dbus_wstrb, 4'b1111);
    check("sw.wdata", dbus_wdata, 32'hDEADBEEF);
    check("sw.we", dbus_we, 1);
    cyc(); #1;
    check("sw.c2_req", dbus_req, 1);
    check("sw.c2_stall", mem_stall, 1);
    cyc(); dbus_ack = 1'b1; #1;
    check("sw.c3_req", dbus_req, 1);
    check("sw.c3_stall", mem_stall, 1);
    check("sw.c3_addr", dbus_addr, 32'h100);
    cyc(); dbus_ack = 1'b0; #1;
    check("sw.c4_req", dbus_req, 0);
    check("sw.c4_stall", mem_stall, 0);
    check("sw.c4_valid", load_valid, 0);
    cyc(); set_op(3'd0, 2'b00, 32'd0, 32'd0);

    run_load("lb",  3'd4, 32'h203, 32'h80FFFF7F, 32'hFFFFFF80);
    run_load("lbu", 3'd5, 32'h203, 32'h80FFFF7F, 32'h00000080);
    run_load("lh",  3'd2, 32'h202, 32'h80FFFF7F, 32'hFFFF80FF);
    run_load("lb0", 3'd4, 32'h200, 32'h80FFFF7F, 32'h0000007F);
    run_load("lw",  3'd1, 32'h400, 32'hCAFEF00D, 32'hCAFEF00D);

    run_store("sb",  2'b11, 32'h301, 32'h12345678, 4'b0010, 32'h78787878);
    run_store("sh",  2'b10, 32'h302, 32'h12345678, 4'b1100, 32'h56785678);
    run_store("sh0", 2'b10, 32'h300, 32'h12345678, 4'b0011, 32'h56785678);
    check("store.keeps_load_data", load_data, 32'hCAFEF00D);

    // Misaligned lw then sh.
    cyc(); set_op(3'd1, 2'b00, 32'h401, 32'd0); #1;
    check("lw_mis.exc", addr_exc, 1);
    check("lw_mis.code", exc_code, 4);
    check("lw_mis.badv", bad_vaddr, 32'h401);
    check("lw_mis.stall", mem_stall, 0);
    cyc(); #1;
    check("lw_mis.req", dbus_req, 0);
    check("lw_mis.stall2", mem_stall, 0);
    cyc(); set_op(3'd0, 2'b10, 32'h401, 32'h1); #1;
    check("sh_mis.exc", addr_exc, 1);
    check("sh_mis.code", exc_code, 5);
    cyc(); #1;
    check("sh_mis.req", dbus_req, 0);
    set_op(3'd0, 2'b00, 32'd0, 32'd0); #1;
    check("no_op.exc", addr_exc, 0);
    check("no_op.code", exc_code, 0);

    // Ack outside BUSY must be ignored.
    cyc(); dbus_ack = 1'b1; dbus_rdata = 32'h11111111;
    cyc(); dbus_ack = 1'b0; #1;
    check("stray_ack.req", dbus_req, 0);
    check("stray_ack.data", load_data, 32'hCAFEF00D);

    // Watchdog: TIMEOUT=4, ack held low.
    cyc(); set_op(3'd1, 2'b00, 32'h500, 32'd0); #1;
    check("wd.idle_stall", mem_stall, 1);
    for (int k = 1; k <= 4; k++) begin
      cyc(); #1;
      check($sformatf("wd.busy%0d_req", k), dbus_req, 1);
      check($sformatf("wd.busy%0d_err", k), bus_err, 0);
    end
    cyc(); #1;
    check("wd.err", bus_err, 1);
    check("wd.req_drop", dbus_req, 0);
    check("wd.data", load_data, 0);
    check("wd.stall", mem_stall, 0);
    cyc(); set_op(3'd0, 2'b00, 32'd0, 32'd0); #1;
    check("wd.err_pulse", bus_err, 0);

    // Reset during BUSY with an ack in the same cycle.
    run_load("lbu2", 3'd5, 32'h203, 32'h80FFFF7F, 32'h00000080);
    cyc(); set_op(3'd1, 2'b00, 32'h600, 32'd0);
    cyc(); #1;
    check("rb.req", dbus_req, 1);
    dbus_ack = 1'b1; dbus_rdata = 32'h12345678; reset = 1'b1;
    cyc(); #1;
    check("rb.req_after", dbus_req, 0);
    check("rb.data", load_data, 0);
    check("rb.valid", load_valid, 0);
    dbus_ack = 1'b0; reset = 1'b0; set_op(3'd0, 2'b00, 32'd0, 32'd0); #1;
    check("rb.stall", mem_stall, 0);

    // pipe_hold keeps DONE and load_valid.
    cyc(); set_op(3'd3, 2'b00, 32'h202, 32'd0);
    cyc(); dbus_ack = 1'b1; dbus_rdata = 32'h80FFFF7F; pipe_hold = 1'b1; #1;
    check("ph.req", dbus_req, 1);
    cyc(); dbus_ack = 1'b0; #1;
    check("ph.valid1", load_valid, 1);
    check("ph.data", load_data, 32'h000080FF);
    check("ph.stall1", mem_stall, 0);
    cyc(); #1;
    check("ph.valid2", load_valid, 1);
    check("ph.req2", dbus_req, 0);
    pipe_hold = 1'b0;
    cyc(); set_op(3'd0, 2'b00, 32'd0, 32'd0); #1;
    check("ph.valid_off", load_valid, 0);
    check("ph.req_off", dbus_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access controller for the five-stage MIPS pipeline. It consumes the memory-control fields latched by the EX/MEM pipeline register and turns each load/store into one request/acknowledge transaction on the data bus, stalling the pipeline until the transaction completes. It performs byte/halfword lane steering, load sign/zero extension, misaligned-address exception detection and a bus watchdog.

## Interface
- TIMEOUT, 255: maximum cycles `dbus_req` may wait for `dbus_ack`; 0 disables the watchdog.

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- mem_read  in  3  load op: 000 none, 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu; 110/111 treated as none
- mem_write  in  2  store op: 00 none, 01 sw, 10 sh, 11 sb
- alu_out  in  32  effective byte address
- store_data  in  32  store source register value (busB)
- pipe_hold  in  1  another stall source is holding the pipeline
- dbus_req  out  1  bus request, registered
- dbus_we  out  1  1 = write
- dbus_addr  out  32  word address, `{alu_out[31:2],2'b00}`
- dbus_wstrb  out  4  byte enables, bit i = byte lane i (little-endian)
- dbus_wdata  out  32  lane-steered write data
- dbus_rdata  in  32  read data, valid with `dbus_ack`
- dbus_ack  in  1  transaction complete
- mem_stall  out  1  freeze IF..EX/MEM, combinational
- load_data  out  32  extended load result
- load_valid  out  1  `load_data` valid for the current MEM instruction
- addr_exc  out  1  misaligned access, combinational
- exc_code  out  5  4 = AdEL, 5 = AdES, 0 otherwise
- bad_vaddr  out  32  `alu_out` when `addr_exc`, else 0
- bus_err  out  1  one-cycle pulse on watchdog expiry

## Operation
- Op present: `mem_read` valid or `mem_write != 00`; a valid load takes priority over a store if both are present.
- Misaligned: lw/sw with `addr[1:0]!=0`; lh/lhu/sh with `addr[0]!=0`. Raises `addr_exc`, AdEL for loads, AdES for stores; no bus access and no stall.
- FSM states IDLE, BUSY, DONE.
  - IDLE: an aligned op moves to BUSY. On entry to BUSY, register `dbus_req=1` together with `we`, `addr`, `wstrb` and `wdata`, and clear the wait counter.
  - BUSY: `dbus_ack=1` captures extended `dbus_rdata` into `load_data` (stores capture nothing) and moves to DONE. Otherwise the wait counter increments. If `TIMEOUT!=0` and the counter reaches `TIMEOUT`, drop the request, set `load_data=0`, pulse `bus_err`, and move to DONE.
  - DONE: `dbus_req=0`. Stay while `pipe_hold=1`; otherwise return to IDLE.
- `mem_stall` = (IDLE and aligned op) or BUSY.
- Stores:
  - sw: `wstrb=1111`, `wdata=store_data`.
  - sh: `wstrb` 0011 or 1100 selected by `addr[1]`, `wdata={2{store_data[15:0]}}`.
  - sb: `wstrb=0001<<addr[1:0]`, `wdata={4{store_data[7:0]}}`.
- Loads: `dbus_we=0`, `wstrb=0000`. The byte or halfword is selected by `addr[1:0]`; lb/lh sign-extend, lbu/lhu zero-extend.
- `load_valid=1` only in DONE for a load.

## Timing
- Reset values: state IDLE; `dbus_req`, `dbus_we`, `load_valid`, `bus_err` = 0; `dbus_addr`, `dbus_wstrb`, `dbus_wdata`, `load_data` = 0. `mem_stall`, `addr_exc`, `exc_code` and `bad_vaddr` follow their inputs.
- Minimum latency with same-cycle ack:
  - cycle 0: IDLE, stall=1.
  - cycle 1: BUSY, req=1, ack=1, stall=1.
  - cycle 2: DONE, stall=0, `load_valid=1`.
  - The pipeline advances at the end of cycle 2.
- `dbus_ack` is ignored outside BUSY. Request fields are stable for the whole of BUSY.
- Reset during BUSY: IDLE and `req=0` at the next edge; an ack in the reset cycle is ignored.
- Watchdog: with `TIMEOUT=N` and no ack, `bus_err` is high for exactly one cycle, N cycles after BUSY entry. That cycle is the DONE entry.
- Back-to-back ops: the op following DONE is evaluated in IDLE on the next cycle.

## Test plan
- sw at 0x100, data 0xDEADBEEF, ack after 2 wait cycles -> req for 3 cycles with addr 0x100, wstrb 1111; stall high for 4 cycles; no `load_valid`.
- lb at 0x203, rdata 0x80FF_FF7F -> `load_data` 0xFFFFFF80. lbu at 0x203, same rdata -> 0x00000080. lh at 0x202 -> 0xFFFF80FF.
- sb at 0x301, data 0x12345678 -> wstrb 0010, wdata 0x78787878. sh at 0x302 -> wstrb 1100, wdata 0x56785678.
- lw at 0x401 -> `addr_exc=1`, exc_code 4, bad_vaddr 0x401, req never rises, stall 0. sh at 0x401 -> exc_code 5.
- TIMEOUT=4 with ack held low -> `bus_err` pulses on the 4th cycle after BUSY entry, `load_data` 0, req drops.
- Reset asserted while BUSY with ack arriving in the same cycle -> next cycle IDLE, req 0, `load_data` 0. `pipe_hold=1` in DONE holds DONE and `load_valid` for those cycles.
